// File: rtl/sdram_req_arbiter.sv
// Request front-end for the 8-bit SDRAM controller: merges a buffered write stream and a
// CPU byte-read port into one controller request at a time, with a one-entry read cache.
module sdram_req_arbiter #(
    parameter int FIFO_DEPTH    = 4,
    parameter int RD_GAP_CYCLES = 8,
    parameter int MAX_WR_BURST  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [24:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        rd_req,
    input  logic [24:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_done,
    output logic [7:0]  rd_data,
    output logic [24:0] sd_raddr,
    output logic        sd_rd,
    input  logic        sd_rd_rdy,
    input  logic [7:0]  sd_dout,
    output logic [24:0] sd_waddr,
    output logic [7:0]  sd_din,
    output logic        sd_we,
    input  logic        sd_we_ack
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(MAX_WR_BURST + 1);
    localparam int GW = $clog2(RD_GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_HI,
        RD_ACC,
        RD_DATA,
        RD_GAP
    } state_t;

    state_t state, next_state;

    logic [24:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, fifo_count;
    logic          fifo_empty, fifo_full;
    logic [24:0]   head_addr;
    logic [7:0]    head_data;
    logic          push, pop;

    logic          start_rd, rd_finish, wr_finish;
    logic [24:0]   pend_addr;
    logic          hazard;
    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] gap_cnt;

    logic          cache_valid;
    logic [24:0]   cache_addr;
    logic [7:0]    cache_data;

    logic          accept, hit, pend_match, issue_match, cache_fwd;
    logic [7:0]    hit_data;
    logic [PW-1:0] offset, idx;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_addr  = fifo_addr[rd_ptr[PW-1:0]];
    assign head_data  = fifo_data[rd_ptr[PW-1:0]];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign wr_ready = !reset && (!fifo_full || pop);
    assign push     = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        start_rd   = 1'b0;
        rd_finish  = 1'b0;
        wr_finish  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_busy && !hazard && (fifo_empty || burst_cnt == BW'(MAX_WR_BURST))) begin
                    start_rd   = 1'b1;
                    next_state = RD_HI;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (sd_we_ack == sd_we) begin
                    wr_finish  = 1'b1;
                    next_state = IDLE;
                end
            end
            RD_HI: begin
                if (!sd_rd_rdy) begin
                    next_state = RD_ACC;
                end
            end
            RD_ACC: begin
                if (sd_rd_rdy) begin
                    rd_finish  = 1'b1;
                    next_state = RD_GAP;
                end
            end
            RD_GAP: begin
                if (gap_cnt == GW'(RD_GAP_CYCLES - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Queued writes to the read address (excluding the one leaving now) make the cache stale.
    always_comb begin
        pend_match = push && (wr_addr == rd_addr);
        offset     = '0;
        idx        = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx    = PW'(i);
            offset = idx - rd_ptr[PW-1:0];
            if (({1'b0, offset} < fifo_count) && !(pop && offset == '0) &&
                (fifo_addr[idx] == rd_addr)) begin
                pend_match = 1'b1;
            end
        end
    end

    assign issue_match = (pop && head_addr == rd_addr) ||
                         (state == WR_WAIT && sd_we != sd_we_ack && sd_waddr == rd_addr);
    assign cache_fwd   = pop && cache_valid && (head_addr == cache_addr);
    assign accept      = rd_req && !rd_busy;
    assign hit         = cache_valid && (cache_addr == rd_addr) && !pend_match;
    assign hit_data    = cache_fwd ? head_data : cache_data;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]] <= wr_addr;
            fifo_data[wr_ptr[PW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            rd_data     <= '0;
            sd_rd       <= 1'b0;
            sd_raddr    <= '0;
            sd_waddr    <= '0;
            sd_din      <= '0;
            sd_we       <= sd_we_ack;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
            pend_addr   <= '0;
            hazard      <= 1'b0;
            burst_cnt   <= '0;
            gap_cnt     <= '0;
        end else begin
            rd_done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                sd_waddr <= head_addr;
                sd_din   <= head_data;
                sd_we    <= ~sd_we;
                if (rd_busy && burst_cnt != BW'(MAX_WR_BURST)) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
                if (cache_fwd) begin
                    cache_data <= head_data;
                end
            end
            if (accept) begin
                if (hit) begin
                    rd_done <= 1'b1;
                    rd_data <= hit_data;
                end else begin
                    rd_busy   <= 1'b1;
                    pend_addr <= rd_addr;
                    hazard    <= pend_match || issue_match;
                end
            end else if (wr_finish && rd_busy && fifo_empty) begin
                hazard <= 1'b0;
            end
            if (start_rd) begin
                sd_raddr <= pend_addr;
                sd_rd    <= 1'b1;
            end
            if (rd_finish) begin
                rd_data     <= sd_dout;
                rd_done     <= 1'b1;
                rd_busy     <= 1'b0;
                sd_rd       <= 1'b0;
                burst_cnt   <= '0;
                gap_cnt     <= '0;
                cache_valid <= 1'b1;
                cache_addr  <= sd_raddr;
                cache_data  <= sd_dout;
            end
            if (state == RD_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter with a small SDRAM controller model behind it.
module tb_sdram_req_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [24:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic        rd_busy;
    logic        rd_done;
    logic [7:0]  rd_data;
    logic [24:0] sd_raddr;
    logic        sd_rd;
    logic        sd_rd_rdy = 1'b1;
    logic [7:0]  sd_dout = 8'h00;
    logic [24:0] sd_waddr;
    logic [7:0]  sd_din;
    logic        sd_we;
    logic        sd_we_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    logic        hold_ack = 1'b0;
    int          ack_cnt = 0, wcnt = 0, wtog = 0, viol = 0;
    int          rd_edges = 0, rphase = 0, rcnt = 0, low_cnt = 0, last_gap = 0;
    int          rise_wtog = 0, done_cnt = 0;
    logic        prev_rd = 1'b0, prev_we = 1'b0, prev_ack = 1'b0;
    logic [24:0] raddr_l = '0;
    logic [24:0] wlog_addr [0:63];
    logic [7:0]  wlog_data [0:63];

    sdram_req_arbiter dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_done(rd_done),
        .rd_data(rd_data), .sd_raddr(sd_raddr), .sd_rd(sd_rd), .sd_rd_rdy(sd_rd_rdy),
        .sd_dout(sd_dout), .sd_waddr(sd_waddr), .sd_din(sd_din), .sd_we(sd_we),
        .sd_we_ack(sd_we_ack)
    );

    always #5 clk = ~clk;

    // Memory seen by the model: latest logged write wins, else a fixed address pattern.
    function automatic logic [7:0] model_rd(input logic [24:0] a);
        logic [7:0] v;
        v = a[7:0] ^ 8'h3C;
        if (a == 25'h200) v = 8'h5C;
        for (int i = 0; i < 64; i++) begin
            if (i < wcnt && wlog_addr[i] == a) v = wlog_data[i];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        prev_we  <= sd_we;
        prev_ack <= sd_we_ack;
        if (sd_we != prev_we) begin
            wtog <= wtog + 1;
            if (prev_we != prev_ack) viol <= viol + 1;
        end
        if (sd_rd && (sd_we != sd_we_ack)) viol <= viol + 1;
        if (sd_we != sd_we_ack && !hold_ack) begin
            if (ack_cnt == 2) begin
                sd_we_ack <= sd_we;
                ack_cnt   <= 0;
                if (wcnt < 64) begin
                    wlog_addr[wcnt] <= sd_waddr;
                    wlog_data[wcnt] <= sd_din;
                end
                wcnt <= wcnt + 1;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        prev_rd <= sd_rd;
        low_cnt <= sd_rd ? 0 : low_cnt + 1;
        if (rd_done) done_cnt <= done_cnt + 1;
        if (sd_rd && !prev_rd) begin
            rd_edges  <= rd_edges + 1;
            last_gap  <= low_cnt;
            rise_wtog <= wtog;
        end
        case (rphase)
            0: if (sd_rd && !prev_rd) begin
                raddr_l <= sd_raddr;
                rcnt    <= 0;
                rphase  <= 1;
            end
            1: if (rcnt == 1) begin
                sd_rd_rdy <= 1'b0;
                rcnt      <= 0;
                rphase    <= 2;
            end else begin
                rcnt <= rcnt + 1;
            end
            2: if (rcnt == 4) begin
                sd_dout   <= model_rd(raddr_l);
                sd_rd_rdy <= 1'b1;
                rphase    <= 0;
            end else begin
                rcnt <= rcnt + 1;
            end
            default: rphase <= 0;
        endcase
    end

    task automatic push_wr(input logic [24:0] a, input logic [7:0] d);
        bit ok = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 200; i++) begin
            if (wr_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("[TB] FAIL push_timeout: addr %h not accepted, want accepted", a);
        end
    endtask

    task automatic do_rd(input logic [24:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic wait_done(input int start);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > start) break;
            @(negedge clk);
        end
        if (done_cnt <= start) begin
            total++; bad++;
            $display("[TB] FAIL rd_done_timeout: got no rd_done, want one");
        end
    endtask

    task automatic wait_writes(input int target);
        for (int i = 0; i < 400; i++) begin
            if (wcnt >= target) break;
            @(negedge clk);
        end
        if (wcnt < target) begin
            total++; bad++;
            $display("[TB] FAIL write_timeout: got %0d writes, want %0d", wcnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_ready: got %b want 0", wr_ready); end
        total++; if ({rd_busy, rd_done, sd_rd} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags: got %b want 000", {rd_busy, rd_done, sd_rd}); end
        total++; if ({rd_data, sd_din} !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data: got %h want 0000", {rd_data, sd_din}); end
        total++; if ({sd_raddr, sd_waddr} !== 50'h0) begin bad++; $display("[TB] FAIL reset_addr: got %h want 0", {sd_raddr, sd_waddr}); end
        total++; if (sd_we !== sd_we_ack) begin bad++; $display("[TB] FAIL reset_we: got %b want %b", sd_we, sd_we_ack); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_writes();
        int base = wcnt;
        int tog0 = wtog;
        logic [24:0] ea [3] = '{25'h100, 25'h101, 25'h102};
        logic [7:0]  ed [3] = '{8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 3; i++) push_wr(ea[i], ed[i]);
        wait_writes(base + 3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wlog_addr[base+i] !== ea[i] || wlog_data[base+i] !== ed[i]) begin
                bad++;
                $display("[TB] FAIL write_order_%0d: got %h<-%h want %h<-%h", i, wlog_addr[base+i], wlog_data[base+i], ea[i], ed[i]);
            end
        end
        total++; if (wtog - tog0 != 3) begin bad++; $display("[TB] FAIL write_toggles: got %0d want 3", wtog - tog0); end
    endtask

    task automatic test_read_and_hit();
        int e0 = rd_edges;
        int d0 = done_cnt;
        int e1;
        do_rd(25'h200);
        total++; if (rd_busy !== 1'b1) begin bad++; $display("[TB] FAIL miss_busy: got %b want 1", rd_busy); end
        wait_done(d0);
        total++; if (rd_data !== 8'h5C) begin bad++; $display("[TB] FAIL miss_data: got %h want 5c", rd_data); end
        total++; if (rd_edges - e0 != 1) begin bad++; $display("[TB] FAIL miss_edges: got %0d want 1", rd_edges - e0); end
        e1 = rd_edges;
        do_rd(25'h200);
        total++; if ({rd_done, rd_busy, rd_data} !== {2'b10, 8'h5C}) begin bad++; $display("[TB] FAIL hit_1cycle: got done=%b busy=%b data=%h want done=1 busy=0 data=5c", rd_done, rd_busy, rd_data); end
        repeat (3) @(negedge clk);
        total++; if (rd_edges != e1) begin bad++; $display("[TB] FAIL hit_no_sd_rd: got %0d edges want %0d", rd_edges, e1); end
        d0 = done_cnt;
        do_rd(25'h208);
        wait_done(d0);
        total++; if (rd_data !== 8'h34) begin bad++; $display("[TB] FAIL second_miss_data: got %h want 34", rd_data); end
        total++; if (last_gap < 8) begin bad++; $display("[TB] FAIL rd_gap: got %0d low cycles want >=8", last_gap); end
    endtask

    task automatic test_fifo_full();
        int base;
        bit  stalled_ok = 1;
        bit  seen = 0;
        repeat (12) @(negedge clk);
        base = wcnt;
        hold_ack = 1'b1;
        for (int i = 0; i < 5; i++) push_wr(25'h700 + 25'(i), 8'h10 + 8'(i));
        total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL fifo_full_ready: got %b want 0", wr_ready); end
        wr_valid = 1'b1; wr_addr = 25'h705; wr_data = 8'h15;
        repeat (3) begin
            @(negedge clk);
            if (wr_ready !== 1'b0) stalled_ok = 0;
        end
        total++; if (!stalled_ok) begin bad++; $display("[TB] FAIL fifo_stall: got ready=1 want 0 while full"); end
        hold_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wr_ready) begin seen = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        total++; if (!seen || wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL pop_push_full: got seen=%b ready=%b want seen=1 ready=0", seen, wr_ready); end
        wait_writes(base + 6);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (wlog_addr[base+i] !== 25'h700 + 25'(i) || wlog_data[base+i] !== 8'h10 + 8'(i)) begin
                bad++;
                $display("[TB] FAIL full_order_%0d: got %h<-%h want %h<-%h", i, wlog_addr[base+i], wlog_data[base+i], 25'h700 + 25'(i), 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_burst();
        int base = wcnt;
        int tog_acc;
        int d0;
        hold_ack = 1'b1;
        for (int i = 0; i < 5; i++) push_wr(25'h400 + 25'(i), 8'h40 + 8'(i));
        tog_acc = wtog;
        d0 = done_cnt;
        do_rd(25'h300);
        total++; if (rd_busy !== 1'b1) begin bad++; $display("[TB] FAIL burst_busy: got %b want 1", rd_busy); end
        hold_ack = 1'b0;
        for (int i = 5; i < 8; i++) push_wr(25'h400 + 25'(i), 8'h40 + 8'(i));
        wait_done(d0);
        total++; if (rise_wtog - tog_acc != 4) begin bad++; $display("[TB] FAIL burst_count: got %0d writes before read want 4", rise_wtog - tog_acc); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("[TB] FAIL burst_rd_data: got %h want 3c", rd_data); end
        wait_writes(base + 8);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wlog_addr[base+i] !== 25'h400 + 25'(i)) begin
                bad++;
                $display("[TB] FAIL burst_order_%0d: got %h want %h", i, wlog_addr[base+i], 25'h400 + 25'(i));
            end
        end
    endtask

    task automatic test_hazard();
        int d0;
        int e0;
        repeat (12) @(negedge clk);
        hold_ack = 1'b1;
        push_wr(25'h500, 8'h55);
        push_wr(25'h300, 8'h77);
        d0 = done_cnt;
        do_rd(25'h300);
        total++; if ({rd_done, rd_busy} !== 2'b01) begin bad++; $display("[TB] FAIL hazard_no_hit: got done=%b busy=%b want done=0 busy=1", rd_done, rd_busy); end
        hold_ack = 1'b0;
        wait_done(d0);
        total++; if (rd_data !== 8'h77) begin bad++; $display("[TB] FAIL hazard_data: got %h want 77", rd_data); end
        e0 = rd_edges;
        do_rd(25'h300);
        total++; if ({rd_done, rd_data} !== {1'b1, 8'h77}) begin bad++; $display("[TB] FAIL hazard_rehit: got done=%b data=%h want done=1 data=77", rd_done, rd_data); end
        total++; if (rd_edges != e0) begin bad++; $display("[TB] FAIL hazard_rehit_edge: got %0d want %0d", rd_edges, e0); end
    endtask

    task automatic test_reset_mid_read();
        int d0;
        bit  low_seen = 0;
        repeat (12) @(negedge clk);
        do_rd(25'h600);
        for (int i = 0; i < 40; i++) begin
            if (!sd_rd_rdy) begin low_seen = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        total++; if (!low_seen || rd_busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_read_busy: got low=%b busy=%b want low=1 busy=1", low_seen, rd_busy); end
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        total++; if ({sd_rd, rd_busy, wr_ready} !== 3'b000) begin bad++; $display("[TB] FAIL mid_reset_outputs: got %b want 000", {sd_rd, rd_busy, wr_ready}); end
        total++; if (sd_we !== sd_we_ack) begin bad++; $display("[TB] FAIL mid_reset_we: got %b want %b", sd_we, sd_we_ack); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("[TB] FAIL mid_reset_no_done: got %0d pulses want 0", done_cnt - d0); end
        d0 = done_cnt;
        do_rd(25'h300);
        total++; if (rd_busy !== 1'b1) begin bad++; $display("[TB] FAIL cache_invalidated: got busy=%b want 1", rd_busy); end
        wait_done(d0);
        total++; if (rd_data !== 8'h77) begin bad++; $display("[TB] FAIL post_reset_read: got %h want 77", rd_data); end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_writes();
        test_read_and_hit();
        test_fifo_full();
        test_burst();
        test_hazard();
        test_reset_mid_read();
        total++; if (viol != 0) begin bad++; $display("[TB] FAIL protocol: got %0d violations want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
